// File: rtl/com_pkg.sv
// Shared types for the RV32E front end: decoded instruction bundle,
// flush request, opcode constants and ALU funct helpers.
package com_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_ILLEGAL
  } inst_class_e;

  typedef enum logic [4:0] {
    F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU,
    F_XOR, F_SRL, F_SRA, F_OR, F_AND,
    F_BEQ, F_BNE, F_BLT, F_BGE, F_BLTU, F_BGEU,
    F_LB, F_LH, F_LW, F_LBU, F_LHU,
    F_SB, F_SH, F_SW,
    F_IL
  } func_e;

  typedef struct packed {
    logic       used;
    logic [3:0] sel;
  } reg_t;

  typedef struct packed {
    inst_class_e inst_class;
    func_e       func;
    reg_t        rd;
    reg_t        rs1;
    reg_t        rs2;
    logic [31:0] imm;
    logic        has_imm;
    logic        uses_pc;
    logic        illegal;
  } decode_instruction_2_t;

  typedef struct packed {
    decode_instruction_2_t inst;
    logic [31:0]           pc;
  } decode_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } flush_t;

  function automatic func_e alu_func(
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic       is_reg
  );
    func_e fn;
    unique case (f3)
      3'd0: fn = (is_reg && f7 == 7'h20) ? F_SUB : F_ADD;
      3'd1: fn = F_SLL;
      3'd2: fn = F_SLT;
      3'd3: fn = F_SLTU;
      3'd4: fn = F_XOR;
      3'd5: fn = (f7 == 7'h20) ? F_SRA : F_SRL;
      3'd6: fn = F_OR;
      3'd7: fn = F_AND;
    endcase
    return fn;
  endfunction

  // Immediate ALU ops only constrain funct7 for the shifts.
  function automatic logic alu_legal(
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic       is_reg
  );
    logic std;
    logic alt;
    std = (f7 == 7'h00);
    alt = (f7 == 7'h20);
    if (is_reg)
      return std || (alt && (f3 == 3'd0 || f3 == 3'd5));
    if (f3 == 3'd1)
      return std;
    if (f3 == 3'd5)
      return std || alt;
    return 1'b1;
  endfunction

endpackage

// File: rtl/rv32e_decoder.sv
// Combinational RV32E instruction decoder: raw word in,
// decoded bundle out; anything not legal RV32E becomes ILLEGAL.
module rv32e_decoder
  import com_pkg::*;
(
  input  logic [31:0]           inst,
  output decode_instruction_2_t dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rd_i  = inst[11:7];
  assign rs1_i = inst[19:15];
  assign rs2_i = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic        ok;
  logic        wr_rd;
  logic        u1;
  logic        u2;
  logic        rd_u;
  logic        bad;
  logic        has_imm;
  logic        uses_pc;
  inst_class_e cls;
  func_e       fn;
  logic [31:0] imm;

  always_comb begin
    ok      = 1'b1;
    wr_rd   = 1'b0;
    u1      = 1'b0;
    u2      = 1'b0;
    has_imm = 1'b0;
    uses_pc = 1'b0;
    cls     = C_ALU;
    fn      = F_ADD;
    imm     = '0;
    unique case (1'b1)
      opc == OPC_OP: begin
        wr_rd = 1'b1;
        u1    = 1'b1;
        u2    = 1'b1;
        fn    = alu_func(f3, f7, 1'b1);
        ok    = alu_legal(f3, f7, 1'b1);
      end
      opc == OPC_OPIMM: begin
        wr_rd   = 1'b1;
        u1      = 1'b1;
        has_imm = 1'b1;
        imm     = imm_i;
        fn      = alu_func(f3, f7, 1'b0);
        ok      = alu_legal(f3, f7, 1'b0);
      end
      opc == OPC_LUI: begin
        wr_rd   = 1'b1;
        has_imm = 1'b1;
        imm     = imm_u;
      end
      opc == OPC_AUIPC: begin
        wr_rd   = 1'b1;
        has_imm = 1'b1;
        uses_pc = 1'b1;
        imm     = imm_u;
      end
      opc == OPC_LOAD: begin
        cls     = C_LOAD;
        wr_rd   = 1'b1;
        u1      = 1'b1;
        has_imm = 1'b1;
        imm     = imm_i;
        unique case (f3)
          3'd0:    fn = F_LB;
          3'd1:    fn = F_LH;
          3'd2:    fn = F_LW;
          3'd4:    fn = F_LBU;
          3'd5:    fn = F_LHU;
          default: ok = 1'b0;
        endcase
      end
      opc == OPC_STORE: begin
        cls     = C_STORE;
        u1      = 1'b1;
        u2      = 1'b1;
        has_imm = 1'b1;
        imm     = imm_s;
        unique case (f3)
          3'd0:    fn = F_SB;
          3'd1:    fn = F_SH;
          3'd2:    fn = F_SW;
          default: ok = 1'b0;
        endcase
      end
      opc == OPC_BRANCH: begin
        cls     = C_BRANCH;
        u1      = 1'b1;
        u2      = 1'b1;
        has_imm = 1'b1;
        imm     = imm_b;
        unique case (f3)
          3'd0:    fn = F_BEQ;
          3'd1:    fn = F_BNE;
          3'd4:    fn = F_BLT;
          3'd5:    fn = F_BGE;
          3'd6:    fn = F_BLTU;
          3'd7:    fn = F_BGEU;
          default: ok = 1'b0;
        endcase
      end
      opc == OPC_JAL: begin
        cls     = C_JAL;
        wr_rd   = 1'b1;
        has_imm = 1'b1;
        uses_pc = 1'b1;
        imm     = imm_j;
      end
      opc == OPC_JALR: begin
        cls     = C_JALR;
        wr_rd   = 1'b1;
        u1      = 1'b1;
        has_imm = 1'b1;
        imm     = imm_i;
        ok      = (f3 == 3'd0);
      end
      default: ok = 1'b0;
    endcase

    if (inst[1:0] != 2'b11)
      ok = 1'b0;

    // RV32E has only x0..x15; a live field naming x16+ is illegal.
    rd_u = wr_rd && (rd_i != 5'd0);
    bad  = (rd_u && rd_i[4]) || (u1 && rs1_i[4])
        || (u2 && rs2_i[4]);

    dec = '0;
    if (ok && !bad) begin
      dec.inst_class = cls;
      dec.func       = fn;
      dec.rd         = '{used: rd_u, sel: rd_i[3:0]};
      dec.rs1        = '{used: u1, sel: rs1_i[3:0]};
      dec.rs2        = '{used: u2, sel: rs2_i[3:0]};
      dec.imm        = imm;
      dec.has_imm    = has_imm;
      dec.uses_pc    = uses_pc;
    end else begin
      dec.inst_class = C_ILLEGAL;
      dec.func       = F_IL;
      dec.illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched words into a 2-entry skid buffer
// with a registered in_ready and a flush that empties the buffer.
module decode_stage
  import com_pkg::*;
#(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [31:0]           in_pc,
  input  flush_t                flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output decode_instruction_2_t out_inst,
  output logic [31:0]           out_pc
);

  decode_instruction_2_t dec;

  rv32e_decoder u_dec (
    .inst (in_inst),
    .dec  (dec)
  );

  decode_entry_t buf_q [2];
  logic          head_q;
  logic          tail_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          in_ready_q;
  logic          acc;
  logic          cons;
  logic          unused_flush;

  assign unused_flush = ^flush.target;

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign acc       = in_valid && in_ready_q;
  assign cons      = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (flush.valid)
      count_d = 2'd0;
    else if (acc && !cons)
      count_d = count_q + 2'd1;
    else if (!acc && cons)
      count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      // Registering off count_d keeps in_ready free of out_ready paths.
      in_ready_q <= (count_d < 2'd2);
      head_q     <= flush.valid ? 1'b0 : head_q ^ cons;
      tail_q     <= flush.valid ? 1'b0 : tail_q ^ acc;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      buf_q[tail_q] <= '{inst: dec, pc: in_pc};
  end

  assign out_inst = out_valid ? buf_q[head_q].inst : '0;
  assign out_pc   = out_valid ? buf_q[head_q].pc : RESET_PC_TAG;

  a_count_max: assert property (
    @(posedge clk) disable iff (rst) count_q <= 2'(DEPTH)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed words with
// hand-decoded expectations, backpressure, flush and reset.
module tb_decode_stage;
  import com_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [31:0]           in_inst = '0;
  logic [31:0]           in_pc = '0;
  flush_t                flush = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  decode_instruction_2_t out_inst;
  logic [31:0]           out_pc;

  int checks = 0;
  int errors = 0;

  decode_entry_t sb_q [$];
  decode_entry_t exp_cur;
  decode_entry_t mon_e;

  decode_instruction_2_t e_addi, e_lui, e_beq, e_ill, e_sub;
  decode_instruction_2_t e_lw, e_sw, e_jal;

  always #5 clk = ~clk;

  decode_stage #(
    .DEPTH        (2),
    .RESET_PC_TAG (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc)
  );

  function automatic decode_instruction_2_t mk(
    inst_class_e c, func_e f,
    logic rdu, logic [3:0] rds,
    logic r1u, logic [3:0] r1s,
    logic r2u, logic [3:0] r2s,
    logic [31:0] imm, logic hi, logic up
  );
    decode_instruction_2_t d;
    d = '0;
    d.inst_class = c;
    d.func       = f;
    d.rd         = '{used: rdu, sel: rds};
    d.rs1        = '{used: r1u, sel: r1s};
    d.rs2        = '{used: r2u, sel: r2s};
    d.imm        = imm;
    d.has_imm    = hi;
    d.uses_pc    = up;
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected entry is queued when the handshake will fire.
  always @(negedge clk) begin
    if (!rst && !flush.valid && in_valid && in_ready)
      sb_q.push_back(exp_cur);
  end

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got pc %h inst %h expected none",
                   out_pc, out_inst);
        end else begin
          mon_e = sb_q.pop_front();
          if (out_inst !== mon_e.inst || out_pc !== mon_e.pc) begin
            errors++;
            $display("FAIL sb_out: got pc %h inst %h expected pc %h inst %h",
                     out_pc, out_inst, mon_e.pc, mon_e.inst);
          end
        end
      end
      if (flush.valid)
        sb_q.delete();
    end
  end

  task automatic drive(input logic [31:0] w, input logic [31:0] p,
                       input decode_instruction_2_t e);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_inst  = w;
    in_pc    = p;
    exp_cur  = '{inst: e, pc: p};
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: got no accept expected accept pc %h", p);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    e_addi = mk(C_ALU, F_ADD, 1, 4'd1, 1, 4'd2, 0, 4'd5,
                32'd5, 1, 0);
    e_lui  = mk(C_ALU, F_ADD, 1, 4'd5, 0, 4'd8, 0, 4'd3,
                32'h12345000, 1, 0);
    e_beq  = mk(C_BRANCH, F_BEQ, 0, 4'd13, 1, 4'd1, 1, 4'd2,
                32'hFFFFFFFC, 1, 0);
    e_sub  = mk(C_ALU, F_SUB, 1, 4'd1, 1, 4'd2, 1, 4'd3,
                32'd0, 0, 0);
    e_lw   = mk(C_LOAD, F_LW, 1, 4'd3, 1, 4'd2, 0, 4'd8,
                32'd8, 1, 0);
    e_sw   = mk(C_STORE, F_SW, 0, 4'd12, 1, 4'd2, 1, 4'd5,
                32'd12, 1, 0);
    e_jal  = mk(C_JAL, F_ADD, 1, 4'd1, 0, 4'd0, 0, 4'd8,
                32'd8, 1, 1);
    e_ill  = '0;
    e_ill.inst_class = C_ILLEGAL;
    e_ill.func       = F_IL;
    e_ill.illegal    = 1'b1;

    idle(2);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive(32'h00510093, 32'h100, e_addi);
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_pc", out_pc, 32'h100);
    chk("lat_inst", out_inst, e_addi);
    @(posedge clk);
    #1;

    drive(32'h123452B7, 32'h104, e_lui);
    drive(32'hFE208EE3, 32'h108, e_beq);
    drive(32'h00000000, 32'h10C, e_ill);
    drive(32'h00208833, 32'h110, e_ill);
    drive(32'h203100B3, 32'h114, e_ill);
    drive(32'h403100B3, 32'h118, e_sub);
    drive(32'h00812183, 32'h11C, e_lw);
    drive(32'h00512623, 32'h120, e_sw);
    drive(32'h008000EF, 32'h124, e_jal);
    idle(3);

    out_ready = 1'b0;
    drive(32'h00510093, 32'h180, e_addi);
    drive(32'h403100B3, 32'h184, e_sub);
    in_valid = 1'b1;
    in_inst  = 32'h008000EF;
    in_pc    = 32'h188;
    exp_cur  = '{inst: e_jal, pc: 32'h188};
    @(negedge clk);
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head_pc", out_pc, 32'h180);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_lag", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_back", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(3);

    out_ready = 1'b0;
    drive(32'h00812183, 32'h200, e_lw);
    drive(32'h00512623, 32'h204, e_sw);
    in_valid    = 1'b1;
    in_inst     = 32'h00510093;
    in_pc       = 32'h208;
    exp_cur     = '{inst: e_addi, pc: 32'h208};
    flush.valid = 1'b1;
    @(negedge clk);
    chk("fl2_pre_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush.valid = 1'b0;
    in_valid    = 1'b0;
    @(negedge clk);
    chk("fl2_out_valid", out_valid, 1'b0);
    chk("fl2_in_ready", in_ready, 1'b1);
    chk("fl2_out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    idle(3);

    out_ready = 1'b0;
    drive(32'hFE208EE3, 32'h300, e_beq);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_inst     = 32'h123452B7;
    in_pc       = 32'h304;
    exp_cur     = '{inst: e_lui, pc: 32'h304};
    flush.valid = 1'b1;
    @(negedge clk);
    chk("fl1_pre_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    flush.valid = 1'b0;
    in_valid    = 1'b0;
    @(negedge clk);
    chk("fl1_out_valid", out_valid, 1'b0);
    chk("fl1_in_ready", in_ready, 1'b1);
    idle(3);

    drive(32'h00510093, 32'h400, e_addi);
    idle(2);

    out_ready = 1'b0;
    drive(32'h403100B3, 32'h500, e_sub);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_out_pc", out_pc, 32'h0);
    chk("mrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    idle(4);
    @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
